// File: rtl/fios_res_collector.sv
// Result collector for the FIOS PE chain: gathers s result words, LSW first,
// and hands the assembled s*W-bit product to the consumer via valid/ready.
module fios_res_collector #(
   parameter int unsigned s    = 16,
   parameter int unsigned W    = 17,
   localparam int unsigned CntW = $clog2(s + 1)
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              res_push_i,
   input  logic [W-1:0]      res_word_i,
   input  logic              done_i,
   input  logic              res_ready_i,
   output logic [s*W-1:0]    res_o,
   output logic              res_valid_o,
   output logic              busy_o,
   output logic [CntW-1:0]   count_o,
   output logic              err_o
);

   localparam logic [CntW-1:0] FullCount = CntW'(s);

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StValid
   } state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       buf_q [s];
   logic [W-1:0]       buf_d [s];
   logic [CntW-1:0]    count_q, count_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               wr_en;

   // Next-state, counter, error and buffer-write decode.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      wr_en   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StCollect;
               count_d = '0;
               err_d   = 1'b0;
            end
         end

         StCollect: begin
            if (start_i) begin
               // Restart wins; a push in the same cycle belongs to the old run.
               count_d = '0;
               err_d   = 1'b0;
            end else begin
               if (res_push_i) begin
                  if (count_q < FullCount) begin
                     wr_en   = 1'b1;
                     count_d = count_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               // count_d already includes a push coinciding with done.
               if (done_i) begin
                  if (count_d == FullCount) begin
                     state_d = StValid;
                  end else begin
                     state_d = StIdle;
                     err_d   = 1'b1;
                  end
               end
            end
         end

         StValid: begin
            // Pushes while a result is held indicate the consumer fell behind.
            if (res_push_i) begin
               err_d = 1'b1;
            end
            if (res_ready_i) begin
               if (start_i) begin
                  state_d = StCollect;
                  count_d = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      valid_d = (state_d == StValid);
      busy_d  = (state_d == StCollect);
   end

   // Buffer write: only the word addressed by the current count is replaced.
   always_comb begin
      for (int k = 0; k < int'(s); k++) begin
         buf_d[k] = buf_q[k];
         if (wr_en && (count_q == CntW'(k))) begin
            buf_d[k] = res_word_i;
         end
      end
   end

   // Control and status registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         count_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // Result word buffer.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k < int'(s); k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(s); k++) begin
            buf_q[k] <= buf_d[k];
         end
      end
   end

   for (genvar g = 0; g < int'(s); g++) begin : g_res
      assign res_o[g*W +: W] = buf_q[g];
   end

   assign res_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign count_o     = count_q;
   assign err_o       = err_q;

endmodule
